// File: rtl/ram_master_lsu.sv
// ram_master_lsu
//   Load/store initiator for a 64-bit doubleword RAM port. Accepts one core
//   access at a time, runs an aligned read, a read-modify-write (sub-dword
//   store) or a direct dword write, then returns load data or a fault.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       core request handshake (ready only in IDLE)
//   req_we/size/unsigned      store flag, 0=B 1=H 2=W 3=D, zero-extend loads
//   req_addr/req_wdata        byte address, store data (LSBs per size)
//   rsp_valid/rsp_ready       response handshake, held until accepted
//   rsp_rdata/rsp_fault       extended load data (0 for stores/faults), fault
//   ram_rw/ram_addr/ram_write RAM cycle: write flag, dword address, write data
//   ram_read/ram_exception    combinational RAM read data and range fault
module ram_master_lsu #(
  parameter int XLEN      = 64,
  parameter int BUS_WIDTH = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault,
  output logic            ram_rw,
  output logic [XLEN-1:0] ram_addr,
  output logic [XLEN-1:0] ram_write,
  input  logic [XLEN-1:0] ram_read,
  input  logic            ram_exception
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t          state, state_next;
  logic            r_we, r_unsigned;
  logic [1:0]      r_size;
  logic [XLEN-1:0] r_addr, r_wdata, r_old;

  logic            accept, misaligned;
  logic [2:0]      align_mask;
  logic [2:0]      off;
  logic [XLEN-1:0] shifted, load_ext;
  logic [7:0]      byte_mask;
  logic [XLEN-1:0] bit_mask, merged;

  assign accept = req_valid && req_ready;
  assign off    = r_addr[BUS_WIDTH-1:0];

  // Low address bits that must be zero for a naturally aligned access.
  always_comb begin
    unique case (req_size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    misaligned = |(req_addr[2:0] & align_mask);
  end

  // Load extraction straight from the RAM read bus, captured at the READ edge.
  always_comb begin
    shifted = ram_read >> {off, 3'b000};
    unique case (r_size)
      2'd0:    load_ext = r_unsigned ? {56'd0, shifted[7:0]}
                                     : {{56{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = r_unsigned ? {48'd0, shifted[15:0]}
                                     : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    load_ext = r_unsigned ? {32'd0, shifted[31:0]}
                                     : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // Store merge. A dword store has an all-ones mask at offset 0, so the same
  // expression yields req_wdata without needing the (skipped) read data.
  always_comb begin
    unique case (r_size)
      2'd0:    byte_mask = 8'h01;
      2'd1:    byte_mask = 8'h03;
      2'd2:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
    byte_mask = byte_mask << off;
    bit_mask  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
    merged = (r_old & ~bit_mask) | ((r_wdata << {off, 3'b000}) & bit_mask);
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ram_rw     = 1'b0;
    ram_addr   = '0;
    ram_write  = '0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (misaligned)                   state_next = S_RESP;
          else if (req_we && req_size == 2'd3) state_next = S_WRITE;
          else                              state_next = S_READ;
        end
      end
      S_READ: begin
        ram_addr = {r_addr[XLEN-1:BUS_WIDTH], {BUS_WIDTH{1'b0}}};
        if (ram_exception) state_next = S_RESP;
        else if (r_we)     state_next = S_WRITE;
        else               state_next = S_RESP;
      end
      S_WRITE: begin
        ram_rw     = 1'b1;
        ram_addr   = {r_addr[XLEN-1:BUS_WIDTH], {BUS_WIDTH{1'b0}}};
        ram_write  = merged;
        state_next = S_RESP;
      end
      default: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_old      <= '0;
      rsp_rdata  <= '0;
      rsp_fault  <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_size     <= req_size;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_old      <= '0;
            rsp_rdata  <= '0;
            rsp_fault  <= misaligned;
          end
        end
        S_READ: begin
          r_old <= ram_read;
          if (ram_exception) rsp_fault <= 1'b1;
          else if (!r_we)    rsp_rdata <= load_ext;
        end
        S_WRITE: begin
          if (ram_exception) rsp_fault <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master_lsu.sv
module tb_ram_master_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_fault;
  logic        ram_rw;
  logic [63:0] ram_addr;
  logic [63:0] ram_write;
  logic [63:0] ram_read;
  logic        ram_exception;

  always #5 clk = ~clk;

  ram_master_lsu #(.XLEN(64), .BUS_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_write(ram_write),
    .ram_read(ram_read), .ram_exception(ram_exception)
  );

  int checks = 0;
  int failures = 0;

  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus-side RAM: 16 dwords (bytes 0..127); anything above is out of range.
  logic        mem_load = 1'b0;
  logic [63:0] init_vals [16];
  logic [63:0] bus_mem [16];
  assign ram_exception = (ram_addr >= 64'd128);
  assign ram_read      = ram_exception ? 64'hDEADBEEFDEADBEEF : bus_mem[ram_addr[6:3]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) bus_mem[i] <= init_vals[i];
    end else if (ram_rw && !ram_exception) begin
      bus_mem[ram_addr[6:3]] <= ram_write;
    end
  end

  // Reference model memory, byte granular.
  logic [7:0] ref_bytes [128];

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          lat;
    int          nwr;
    bit          memchk;
    int          idx;
    logic [63:0] dword;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   wcount = 0;
  bit   seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queue head and
  // drives random response backpressure.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_rw) wcount++;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got rdata %h fault %0b expected no response", rsp_rdata, rsp_fault);
        end else begin
          e = q[0];
          if (!seen) begin
            check("latency", 64'(cyc - acc_cyc + 1), 64'(e.lat));
            seen = 1;
          end
          check("rdata", rsp_rdata, e.rdata);
          check("fault", {63'd0, rsp_fault}, {63'd0, e.fault});
          rsp_ready = ($urandom % 3) != 0;
          if (rsp_ready) begin
            check("write_cycles", 64'(wcount), 64'(e.nwr));
            if (e.memchk) check("mem", bus_mem[e.idx], e.dword);
            void'(q.pop_front());
            seen   = 0;
            wcount = 0;
          end
        end
      end else begin
        rsp_ready = ($urandom % 2) != 0;
      end
    end
  end

  function automatic logic [63:0] ref_load(input logic [63:0] a, input int nb, input bit uns);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v = v | (64'(ref_bytes[a[6:0] + 7'(i)]) << (8 * i));
    if (nb < 8 && !uns && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
    return v;
  endfunction

  function automatic logic [63:0] ref_dword(input int idx);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_bytes[idx*8 + i];
    return v;
  endfunction

  // Issue one access; expectation from the byte-level model unless overridden.
  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input bit use_ovr, input logic [63:0] ovr);
    int   n  = 0;
    int   nb = 1 << size;
    bit   mis = (addr % 64'(nb)) != 0;
    bit   oor = addr >= 64'd128;
    exp_t x;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    x = '{rdata: '0, fault: 1'b0, lat: 0, nwr: 0, memchk: 0, idx: 0, dword: '0};
    if (mis) begin
      x.fault = 1; x.lat = 1;
    end else if (!we) begin
      x.lat = 2;
      if (oor) x.fault = 1;
      else     x.rdata = ref_load(addr, nb, uns);
    end else if (oor) begin
      x.fault = 1; x.lat = 2; x.nwr = (size == 2'd3) ? 1 : 0;
    end else begin
      for (int i = 0; i < nb; i++) ref_bytes[addr[6:0] + 7'(i)] = wdata[8*i +: 8];
      x.lat    = (size == 2'd3) ? 2 : 3;
      x.nwr    = 1;
      x.memchk = 1;
      x.idx    = int'(addr[6:3]);
      x.dword  = ref_dword(x.idx);
    end
    if (use_ovr) x.rdata = ovr;
    q.push_back(x);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_size  = 2'($urandom);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !req_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    init_vals[0] = 64'h0fc1059700100513;
    for (int i = 1; i < 16; i++) init_vals[i] = {$urandom, $urandom};
    for (int i = 0; i < 128; i++) ref_bytes[i] = init_vals[i/8][8*(i%8) +: 8];
    mem_load = 1'b1;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_load = 1'b0;
    rst      = 1'b0;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_fault", {63'd0, rsp_fault}, 64'd0);
    check("rst_ram_rw", {63'd0, ram_rw}, 64'd0);
    check("rst_ram_addr", ram_addr, 64'd0);
    check("rst_ram_write", ram_write, 64'd0);

    // Directed cases with hand-derived values.
    issue(0, 2'd0, 0, 64'd4, '0, 1, 64'hFFFFFFFFFFFFFF97);
    issue(0, 2'd0, 1, 64'd4, '0, 1, 64'h0000000000000097);
    issue(0, 2'd2, 0, 64'd4, '0, 1, 64'h000000000fc10597);
    issue(0, 2'd3, 0, 64'd0, '0, 1, 64'h0fc1059700100513);
    issue(1, 2'd0, 0, 64'd2, 64'h00000000000000AB, 1, 64'd0);
    issue(0, 2'd3, 0, 64'd0, '0, 1, 64'h0fc1059700AB0513);
    issue(1, 2'd3, 0, 64'd8, 64'h1122334455667788, 1, 64'd0);
    issue(0, 2'd3, 1, 64'd8, '0, 1, 64'h1122334455667788);
    issue(0, 2'd1, 0, 64'd3, '0, 1, 64'd0);
    issue(1, 2'd2, 0, 64'd6, 64'hCAFEBABE, 1, 64'd0);
    issue(0, 2'd3, 0, 64'd1 << 20, '0, 1, 64'd0);
    issue(1, 2'd1, 0, (64'd1 << 20) + 64'd2, 64'h5555, 0, 64'd0);

    // Randomized mix: mostly aligned in range, some misaligned / out of range.
    for (int t = 0; t < 300; t++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [63:0] a  = 64'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      if ($urandom_range(0, 9) == 0) a = (64'd1 << 20) + (a & 64'h78);
      issue(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, 0, 64'd0);
    end
    drain();

    // Reset during the WRITE cycle of a sub-dword store aborts it.
    req_we = 1; req_size = 2'd0; req_unsigned = 0; req_addr = 64'd16; req_wdata = 64'h5A;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_write", {63'd0, ram_rw}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wcount = 0;
    check("abort_ram_rw", {63'd0, ram_rw}, 64'd0);
    check("abort_req_ready", {63'd0, req_ready}, 64'd1);
    check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("abort_rsp_fault", {63'd0, rsp_fault}, 64'd0);
    repeat (3) @(negedge clk);
    check("abort_no_write", 64'(wcount), 64'd0);
    check("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
